// File: rtl/vector_recorder_pkg.sv
// Shared types and default sizing for the vector recorder slice.
package vector_recorder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } vr_state_t;

    localparam int VR_WIDTH = 2;
    localparam int VR_DEPTH = 4;

endpackage

// File: rtl/vector_recorder_if.sv
// Control, capture and readout signals of the vector recorder.
interface vector_recorder_if
    import vector_recorder_pkg::*;
#(
    parameter int WIDTH = VR_WIDTH,
    parameter int DEPTH = VR_DEPTH
) ();

    localparam int AW = $clog2(DEPTH);

    logic             start;
    logic             stop;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [AW:0]      count;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, stop, in_valid, in_data, rd_addr,
        input  rd_data, count, busy, done, overflow
    );

    modport slave (
        input  start, stop, in_valid, in_data, rd_addr,
        output rd_data, count, busy, done, overflow
    );

endinterface

// File: rtl/vr_mem.sv
// Vector storage: one write port, one registered read-first read port.
module vr_mem #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Only the output register is cleared; the array keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vector_recorder.sv
// Capture-run FSM, vector counter and sticky overflow around the vr_mem store.
module vector_recorder
    import vector_recorder_pkg::*;
#(
    parameter int WIDTH = VR_WIDTH,
    parameter int DEPTH = VR_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    vector_recorder_if.slave   bus
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    vr_state_t   state;
    logic [AW:0] count;
    logic        overflow;
    logic        full;
    logic        wr_en;

    assign full  = (count == FULL);
    assign wr_en = (state == ST_CAPTURE) && bus.in_valid && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus.in_valid && full) overflow <= 1'b1;
            case (state)
                ST_CAPTURE: begin
                    if (wr_en) count <= count + 1'b1;
                    // The write that fills the last slot ends the run on its own.
                    if (bus.stop || (wr_en && count == LAST)) state <= ST_DONE;
                end
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state    <= ST_CAPTURE;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == ST_CAPTURE);
    assign bus.done     = (state == ST_DONE);
    assign bus.count    = count;
    assign bus.overflow = overflow;

    vr_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .wr_addr (count[AW-1:0]),
        .wr_data (bus.in_data),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );

endmodule

// File: tb/tb_vector_recorder.sv
// Scenario tasks plus a randomized run against a behavioural recorder model.
module tb_vector_recorder;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_recorder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    vector_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    // Behavioural model: phase 0 idle, 1 recording, 2 finished
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_wr  [DEPTH];
    int               m_phase;
    int               m_count;
    bit               m_ovf;
    logic [WIDTH-1:0] m_rd;
    bit               m_rd_known;

    function automatic void model_reset();
        m_phase = 0; m_count = 0; m_ovf = 0; m_rd = '0; m_rd_known = 1;
    endfunction

    function automatic void model_edge();
        m_rd       = m_mem[int'(bus.rd_addr)];
        m_rd_known = m_wr[int'(bus.rd_addr)];
        if (m_phase != 1) begin
            if (bus.start) begin
                m_phase = 1; m_count = 0; m_ovf = 0;
            end else if (bus.in_valid && m_count == DEPTH) begin
                m_ovf = 1;
            end
        end else begin
            if (bus.in_valid) begin
                if (m_count < DEPTH) begin
                    m_mem[m_count] = bus.in_data;
                    m_wr[m_count]  = 1;
                    m_count++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (bus.stop || m_count == DEPTH) m_phase = 2;
        end
    endfunction

    task automatic drive(input bit s, input bit p, input bit v,
                         input logic [WIDTH-1:0] d, input logic [AW-1:0] a);
        bus.start = s; bus.stop = p; bus.in_valid = v; bus.in_data = d; bus.rd_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 2'b00, 2'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 model_reset();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        checks++; if (bus.rd_data !== 2'b00) begin failures++; $display("FAIL reset_rd_data got=%b exp=00", bus.rd_data); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive(1, 0, 0, 2'b00, 2'd0); tick();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
        drive(0, 0, 1, 2'b10, 2'd0); tick();
        drive(0, 0, 1, 2'b01, 2'd0); tick();
        drive(0, 1, 0, 2'b00, 2'd0); tick();
        checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", bus.count); end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", bus.done); end
        drive(0, 0, 0, 2'b00, 2'd0); tick();
        checks++; if (bus.rd_data !== 2'b10) begin failures++; $display("FAIL basic_slot0 got=%b exp=10", bus.rd_data); end
        drive(0, 0, 0, 2'b00, 2'd1); tick();
        checks++; if (bus.rd_data !== 2'b01) begin failures++; $display("FAIL basic_slot1 got=%b exp=01", bus.rd_data); end
    endtask

    task automatic test_fill();
        drive(1, 0, 0, 2'b00, 2'd0); tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 1, 2'(i), 2'd0); tick();
        end
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL fill_done got=%b/%b exp=1/0", bus.done, bus.busy); end
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
        drive(0, 0, 1, 2'b11, 2'd0); tick();
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", bus.overflow); end
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL fill_count_sat got=%0d exp=4", bus.count); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 2'b00, 2'(i)); tick();
            checks++; if (bus.rd_data !== 2'(i)) begin failures++; $display("FAIL fill_slot%0d got=%b exp=%b", i, bus.rd_data, 2'(i)); end
        end
    endtask

    task automatic test_stop_with_write();
        drive(1, 0, 0, 2'b00, 2'd0); tick();
        drive(0, 0, 1, 2'b01, 2'd0); tick();
        drive(0, 1, 1, 2'b11, 2'd0); tick();
        checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL stopwr_count got=%0d exp=2", bus.count); end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL stopwr_done got=%b exp=1", bus.done); end
        drive(0, 0, 0, 2'b00, 2'd1); tick();
        checks++; if (bus.rd_data !== 2'b11) begin failures++; $display("FAIL stopwr_slot1 got=%b exp=11", bus.rd_data); end
    endtask

    task automatic test_reset_mid_capture();
        drive(1, 0, 0, 2'b00, 2'd0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 2'b01, 2'd0); tick();
        end
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL midrst_precount got=%0d exp=3", bus.count); end
        rst = 1'b1;
        #1 model_reset();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", bus.count); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b exp=0", bus.overflow); end
        drive(0, 0, 0, 2'b00, 2'd0);
        release_reset();
        drive(1, 0, 0, 2'b00, 2'd0); tick();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_restart got=%b exp=1", bus.busy); end
        drive(0, 0, 1, 2'b10, 2'd0); tick();
        drive(0, 1, 0, 2'b00, 2'd0); tick();
        checks++; if (bus.rd_data !== 2'b10 || bus.count !== 3'd1) begin failures++; $display("FAIL midrst_slot0 got=%b/%0d exp=10/1", bus.rd_data, bus.count); end
    endtask

    task automatic test_restart();
        drive(1, 0, 0, 2'b00, 2'd0); tick();
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(0, 0, 1, 2'b11, 2'd0); tick();
        end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL restart_pre_ovf got=%b exp=1", bus.overflow); end
        drive(1, 0, 0, 2'b00, 2'd0); tick();
        checks++; if (bus.count !== 3'd0 || bus.overflow !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL restart_clear got=%0d/%b/%b exp=0/0/1", bus.count, bus.overflow, bus.busy); end
        drive(0, 0, 1, 2'b01, 2'd0); tick();
        drive(1, 0, 0, 2'b00, 2'd0); tick();
        checks++; if (bus.count !== 3'd1 || bus.busy !== 1'b1) begin failures++; $display("FAIL restart_in_capture got=%0d/%b exp=1/1", bus.count, bus.busy); end
        drive(0, 1, 0, 2'b00, 2'd0); tick();
    endtask

    task automatic test_read_first();
        drive(1, 0, 0, 2'b00, 2'd0); tick();
        drive(0, 1, 1, 2'b01, 2'd0); tick();
        drive(1, 0, 0, 2'b00, 2'd0); tick();
        drive(0, 0, 1, 2'b10, 2'd0); tick();
        checks++; if (bus.rd_data !== 2'b01) begin failures++; $display("FAIL readfirst_old got=%b exp=01", bus.rd_data); end
        drive(0, 0, 0, 2'b00, 2'd0); tick();
        checks++; if (bus.rd_data !== 2'b10) begin failures++; $display("FAIL readfirst_new got=%b exp=10", bus.rd_data); end
        drive(0, 1, 0, 2'b00, 2'd0); tick();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                drive(0, 0, 0, 2'b00, 2'd0);
                rst = 1'b1;
                #1 model_reset();
                checks++; if (bus.busy !== 1'b0 || bus.count !== 3'd0) begin failures++; $display("FAIL rand_reset got=%b/%0d exp=0/0", bus.busy, bus.count); end
                release_reset();
                continue;
            end
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom));
            tick();
            checks++;
            if (bus.count !== 3'(m_count) || bus.busy !== (m_phase == 1) ||
                bus.done !== (m_phase == 2) || bus.overflow !== m_ovf ||
                (m_rd_known && bus.rd_data !== m_rd)) begin
                failures++;
                if (errs++ < 10)
                    $display("FAIL rand_cycle%0d got cnt=%0d busy=%b done=%b ovf=%b rd=%b exp cnt=%0d phase=%0d ovf=%b rd=%b",
                             n, bus.count, bus.busy, bus.done, bus.overflow, bus.rd_data,
                             m_count, m_phase, m_ovf, m_rd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
        model_reset();
        test_reset();
        test_basic();
        test_fill();
        test_stop_with_write();
        test_reset_mid_capture();
        test_restart();
        test_read_first();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
